reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Run controller that sequences the two block resets of the acquisition chain: the RAM writer and the DAC group (Fourier synth + PDM). It releases the writer first and the DACs a programmable number of cycles later, on an arm command or on an external trigger. On stop it takes the DACs down first and the writer a programmable number of cycles after that. A fault input forces both into reset and latches. It sits between the PS configuration registers and the per-block `*_aresetn` fan-out.

## Interface
Parameters:
- DELAY_WIDTH, 16, width of the delay configuration fields and of the delay counter
- SYNC_STAGES, 2, flip-flop stages in the ext_trigger synchronizer (legal range ≥2)

Ports:
- clk  in  1  system clock (125 MHz)
- peripheral_aresetn  in  1  asynchronous, active-low reset; single clock domain
- arm  in  1  level from PS; high = run requested, low = stop requested
- trigger_mode  in  1  0: start on arm; 1: start on ext_trigger rising edge while armed
- ext_trigger  in  1  asynchronous trigger pin
- fault  in  1  synchronous fault level (watchdog timeout / instant reset)
- fault_clear  in  1  single-cycle pulse from PS
- dac_delay  in  DELAY_WIDTH  cycles between writer release and DAC release
- stop_delay  in  DELAY_WIDTH  cycles between DAC reset and writer reset on stop
- write_to_ram_aresetn  out  1  writer reset, active-low
- dac_aresetn  out  1  DAC-group reset, active-low
- seq_state  out  3  current state encoding
- fault_latched  out  1  sticky fault flag
- run_count  out  16  number of RUN entries, saturating

## Operation
- States and encodings:
  - IDLE=0
  - WAIT_TRIG=1
  - RAM_UP=2
  - RUN=3
  - DAC_DOWN=4
  - FAULT=5
  - 6 and 7 unreachable; if ever entered, go to IDLE.
- Outputs per state:
  - IDLE, WAIT_TRIG, FAULT: both resets low.
  - RAM_UP, DAC_DOWN: write_to_ram_aresetn=1, dac_aresetn=0.
  - RUN: both resets high.
- Transitions are evaluated in priority order: fault > arm low > start/timer.
  - Any state except FAULT, with fault=1: go to FAULT and set fault_latched.
  - IDLE, arm=1: trigger_mode=0 goes to RAM_UP; trigger_mode=1 goes to WAIT_TRIG.
  - WAIT_TRIG: arm=0 goes to IDLE; a synchronized trigger rising edge goes to RAM_UP.
  - RAM_UP: arm=0 goes to IDLE. Otherwise stay until the delay counter equals dac_delay, then go to RUN and increment run_count (saturate at 0xFFFF).
  - RUN: arm=0 goes to DAC_DOWN.
  - DAC_DOWN: stay until the counter equals stop_delay, then go to IDLE. A re-asserted arm is ignored until IDLE is reached.
  - FAULT: exit to IDLE only when fault=0, arm=0 and fault_clear=1, all in the same cycle. That same cycle clears fault_latched.
  - fault_clear in any other state: clears fault_latched if fault=0.
- Delay counter:
  - Cleared on every state entry; increments once per cycle inside RAM_UP or DAC_DOWN.
  - Compared for equality against the delay value sampled on state entry. A PS write mid-delay has no effect on the running delay.
- trigger_mode is sampled only in IDLE.

## Timing
- Reset values:
  - state IDLE
  - both resets 0
  - fault_latched 0
  - run_count 0
  - counter 0
  - synchronizer flops 0
- All outputs are registered and decoded from next-state, so they change on the same edge as seq_state. No combinational path from any input to any output.
- Continuous start: arm first seen high at edge k gives write_to_ram_aresetn=1 after edge k, and dac_aresetn=1 after edge k+dac_delay+1. dac_delay=0 gives a one-cycle stagger.
- Triggered start: the pin rising edge is detected SYNC_STAGES+1 edges later. RAM_UP is entered on that edge.
- Stop: arm low seen at edge k gives dac_aresetn=0 after edge k, and write_to_ram_aresetn=0 after edge k+stop_delay+1.
- Fault: fault high at edge k gives both resets 0 after edge k.
- Asynchronous reset mid-run drives both resets low immediately, without waiting for a clock.

## Structure
- Package reset_seq_pkg holds:
  - the state encoding constants
  - the width constants for run_count and seq_state
- Sub-module sync_rise_detect: SYNC_STAGES synchronizer followed by a one-cycle rising-edge pulse. It is reused later for the other async pins.

## Test plan
- Continuous start: trigger_mode=0, dac_delay=10, arm 0→1 → writer high 1 edge later, DAC high 11 edges after writer; seq_state 2→3; run_count=1.
- Triggered start: trigger_mode=1, arm=1, ext_trigger pulse of 3 cycles → RAM_UP entered exactly SYNC_STAGES+1 edges after the pin edge. A second pulse while in RUN → no effect.
- Stop: in RUN, stop_delay=5, arm 1→0 → DAC low next edge, writer low 6 edges later, seq_state=0. arm re-raised during DAC_DOWN → still returns to IDLE first.
- Fault in RAM_UP: fault=1 for 1 cycle → both resets low next edge, fault_latched=1. fault_clear while arm=1 → stays in FAULT. arm=0 plus fault_clear → IDLE.
- Boundaries:
  - dac_delay=0xFFFF → 65536-cycle stagger.
  - run_count preloaded via 0xFFFF runs → saturates.
  - peripheral_aresetn pulsed low mid-RUN → both resets drop without a clock edge; all reset values restored.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encoding and widths
// shared by the run reset sequencer.
package reset_seq_pkg;

   localparam int STATE_W     = 3;
   localparam int RUN_COUNT_W = 16;

   localparam logic [RUN_COUNT_W-1:0] RUN_COUNT_MAX = '1;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_TRIG = 3'd1,
      ST_RAM_UP    = 3'd2,
      ST_RUN       = 3'd3,
      ST_DAC_DOWN  = 3'd4,
      ST_FAULT     = 3'd5
   } seq_state_e;

   function automatic logic ram_rst_n(
      input seq_state_e s
   );
      return (s == ST_RAM_UP) ||
             (s == ST_RUN) ||
             (s == ST_DAC_DOWN);
   endfunction

   function automatic logic dac_rst_n(
      input seq_state_e s
   );
      return (s == ST_RUN);
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: PS-side control and
// status bundle of the run reset sequencer.
interface reset_sequencer_if #(
   parameter int DELAY_WIDTH = 16
);
   import reset_seq_pkg::*;

   logic                   arm;
   logic                   trigger_mode;
   logic                   fault_clear;
   logic [DELAY_WIDTH-1:0] dac_delay;
   logic [DELAY_WIDTH-1:0] stop_delay;
   logic [STATE_W-1:0]     seq_state;
   logic                   fault_latched;
   logic [RUN_COUNT_W-1:0] run_count;

   modport master (
      output arm,
      output trigger_mode,
      output fault_clear,
      output dac_delay,
      output stop_delay,
      input  seq_state,
      input  fault_latched,
      input  run_count
   );

   modport slave (
      input  arm,
      input  trigger_mode,
      input  fault_clear,
      input  dac_delay,
      input  stop_delay,
      output seq_state,
      output fault_latched,
      output run_count
   );

endinterface

// File: rtl/reset_sequencer_sync_rise_detect.sv
// sync_rise_detect: multi-stage synchronizer
// plus a one-cycle rising-edge pulse.
module sync_rise_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              last_q;
   logic              last_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_i};
      last_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         last_q <= last_d;
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staggers writer and DAC
// block resets on run start/stop and fault.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int DELAY_WIDTH = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic peripheral_aresetn,
   input  logic ext_trigger,
   input  logic fault,
   reset_sequencer_if.slave cfg,
   output logic write_to_ram_aresetn,
   output logic dac_aresetn
);

   seq_state_e             state_q;
   seq_state_e             state_d;
   logic [DELAY_WIDTH-1:0] cnt_q;
   logic [DELAY_WIDTH-1:0] cnt_d;
   logic [DELAY_WIDTH-1:0] lim_q;
   logic [DELAY_WIDTH-1:0] lim_d;
   logic                   flt_q;
   logic                   flt_d;
   logic [RUN_COUNT_W-1:0] run_count_q;
   logic [RUN_COUNT_W-1:0] run_count_d;
   logic                   wr_q;
   logic                   wr_d;
   logic                   dac_q;
   logic                   dac_d;
   logic                   trig_rise;
   logic                   entering;
   logic                   timed;
   logic                   hit;

   sync_rise_detect #(
      .STAGES (SYNC_STAGES)
   ) u_trig (
      .clk     (clk),
      .rst_n   (peripheral_aresetn),
      .async_i (ext_trigger),
      .rise_o  (trig_rise)
   );

   assign hit = (cnt_q == lim_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg.arm) begin
               state_d = cfg.trigger_mode ?
                  ST_WAIT_TRIG : ST_RAM_UP;
            end
         end
         ST_WAIT_TRIG: begin
            if (!cfg.arm)
               state_d = ST_IDLE;
            else if (trig_rise)
               state_d = ST_RAM_UP;
         end
         ST_RAM_UP: begin
            if (!cfg.arm)
               state_d = ST_IDLE;
            else if (hit)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!cfg.arm)
               state_d = ST_DAC_DOWN;
         end
         ST_DAC_DOWN: begin
            if (hit)
               state_d = ST_IDLE;
         end
         ST_FAULT: begin
            if (!fault && !cfg.arm &&
                cfg.fault_clear)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (fault && state_q != ST_FAULT)
         state_d = ST_FAULT;
   end

   // the delay is captured on entry so a PS
   // write mid-delay cannot move the release
   always_comb begin
      entering = (state_d != state_q);
      timed    = (state_q == ST_RAM_UP) ||
                 (state_q == ST_DAC_DOWN);
      cnt_d = cnt_q;
      lim_d = lim_q;
      if (entering) begin
         cnt_d = '0;
         if (state_d == ST_RAM_UP)
            lim_d = cfg.dac_delay;
         else if (state_d == ST_DAC_DOWN)
            lim_d = cfg.stop_delay;
      end else if (timed) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      flt_d = flt_q;
      if (state_q != ST_FAULT) begin
         if (fault)
            flt_d = 1'b1;
         else if (cfg.fault_clear)
            flt_d = 1'b0;
      end else if (state_d == ST_IDLE) begin
         flt_d = 1'b0;
      end
   end

   always_comb begin
      run_count_d = run_count_q;
      if (state_q == ST_RAM_UP &&
          state_d == ST_RUN &&
          run_count_q != RUN_COUNT_MAX)
         run_count_d = run_count_q + 1'b1;
      wr_d  = ram_rst_n(state_d);
      dac_d = dac_rst_n(state_d);
   end

   always_ff @(posedge clk or negedge peripheral_aresetn) begin
      if (!peripheral_aresetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         lim_q       <= '0;
         flt_q       <= 1'b0;
         run_count_q <= '0;
         wr_q        <= 1'b0;
         dac_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lim_q       <= lim_d;
         flt_q       <= flt_d;
         run_count_q <= run_count_d;
         wr_q        <= wr_d;
         dac_q       <= dac_d;
      end
   end

   assign write_to_ram_aresetn = wr_q;
   assign dac_aresetn          = dac_q;
   assign cfg.seq_state        = state_q;
   assign cfg.fault_latched    = flt_q;
   assign cfg.run_count        = run_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed stimulus with an
// expected-event queue checked by a monitor.
module tb_reset_sequencer;
   import reset_seq_pkg::*;

   typedef struct packed {
      int          cyc;
      logic [2:0]  st;
      logic        wr;
      logic        dac;
      logic        fl;
      logic [15:0] rc;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   logic ext_trigger;
   logic fault;
   logic wr;
   logic dac;

   int cyc = 0;
   int tests = 0;
   int fails = 0;
   int t;

   ev_t   exp_q[$];
   string name_q[$];

   reset_sequencer_if #(.DELAY_WIDTH(16)) bus ();

   reset_sequencer #(
      .DELAY_WIDTH (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk                  (clk),
      .peripheral_aresetn   (rst_n),
      .ext_trigger          (ext_trigger),
      .fault                (fault),
      .cfg                  (bus),
      .write_to_ram_aresetn (wr),
      .dac_aresetn          (dac)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(
      input int c, input string n,
      input logic [2:0] s, input logic w,
      input logic d, input logic f,
      input logic [15:0] r
   );
      ev_t e;
      e.cyc = c; e.st = s; e.wr = w;
      e.dac = d; e.fl = f; e.rc = r;
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic chk(
      input string n, input int act,
      input int expv
   );
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d",
                  n, act, expv);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   ev_t last = '0;
   ev_t cur;
   ev_t tmp;
   ev_t e;
   string nm;

   always begin
      @(posedge clk);
      #1;
      cur.cyc = cyc;
      cur.st  = bus.seq_state;
      cur.wr  = wr;
      cur.dac = dac;
      cur.fl  = bus.fault_latched;
      cur.rc  = bus.run_count;
      tmp = cur;
      tmp.cyc = last.cyc;
      if (tmp != last) begin
         last = cur;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected: cyc=%0d st=%0d wr=%0b dac=%0b fl=%0b rc=%h",
                     cur.cyc, cur.st, cur.wr, cur.dac, cur.fl, cur.rc);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e != cur) begin
               fails++;
               $display("FAIL %s: got cyc=%0d st=%0d wr=%0b dac=%0b fl=%0b rc=%h, want cyc=%0d st=%0d wr=%0b dac=%0b fl=%0b rc=%h",
                        nm, cur.cyc, cur.st, cur.wr, cur.dac, cur.fl, cur.rc,
                        e.cyc, e.st, e.wr, e.dac, e.fl, e.rc);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      ext_trigger = 1'b0;
      fault = 1'b0;
      bus.arm = 1'b0;
      bus.trigger_mode = 1'b0;
      bus.fault_clear = 1'b0;
      bus.dac_delay = 16'd0;
      bus.stop_delay = 16'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_state", int'(bus.seq_state), 0);
      chk("rst_wr", int'(wr), 0);
      chk("rst_dac", int'(dac), 0);
      chk("rst_fl", int'(bus.fault_latched), 0);
      chk("rst_rc", int'(bus.run_count), 0);

      // continuous start, mid-delay write ignored
      @(negedge clk);
      bus.dac_delay = 16'd10;
      t = cyc; bus.arm = 1'b1;
      push(t+1, "cont_ram_up", ST_RAM_UP, 1, 0, 0, 0);
      push(t+12, "cont_run", ST_RUN, 1, 1, 0, 1);
      wait_until(t+3);
      bus.dac_delay = 16'd3;
      wait_until(t+15);

      // stop with re-arm during DAC_DOWN
      t = cyc;
      bus.stop_delay = 16'd5;
      bus.dac_delay = 16'd2;
      bus.arm = 1'b0;
      push(t+1, "stop_dac_down", ST_DAC_DOWN, 1, 0, 0, 1);
      push(t+7, "stop_idle", ST_IDLE, 0, 0, 0, 1);
      push(t+8, "rearm_ram_up", ST_RAM_UP, 1, 0, 0, 1);
      push(t+11, "rearm_run", ST_RUN, 1, 1, 0, 2);
      wait_until(t+2);
      bus.arm = 1'b1;
      wait_until(t+13);
      t = cyc;
      bus.stop_delay = 16'd0;
      bus.arm = 1'b0;
      push(t+1, "stop0_dac_down", ST_DAC_DOWN, 1, 0, 0, 2);
      push(t+2, "stop0_idle", ST_IDLE, 0, 0, 0, 2);
      wait_until(t+4);

      // triggered start, second pulse in RUN
      t = cyc;
      bus.trigger_mode = 1'b1;
      bus.dac_delay = 16'd0;
      bus.arm = 1'b1;
      push(t+1, "trig_wait", ST_WAIT_TRIG, 0, 0, 0, 2);
      wait_until(t+4);
      t = cyc;
      ext_trigger = 1'b1;
      push(t+3, "trig_ram_up", ST_RAM_UP, 1, 0, 0, 2);
      push(t+4, "trig_run", ST_RUN, 1, 1, 0, 3);
      wait_until(t+3);
      ext_trigger = 1'b0;
      wait_until(t+8);
      ext_trigger = 1'b1;
      wait_until(t+11);
      ext_trigger = 1'b0;
      wait_until(t+16);
      t = cyc;
      bus.trigger_mode = 1'b0;
      bus.arm = 1'b0;
      push(t+1, "trig_dac_down", ST_DAC_DOWN, 1, 0, 0, 3);
      push(t+2, "trig_idle", ST_IDLE, 0, 0, 0, 3);
      wait_until(t+4);

      // fault in RAM_UP, clear needs arm low
      t = cyc;
      bus.dac_delay = 16'd20;
      bus.arm = 1'b1;
      push(t+1, "flt_ram_up", ST_RAM_UP, 1, 0, 0, 3);
      wait_until(t+3);
      fault = 1'b1;
      push(t+4, "flt_enter", ST_FAULT, 0, 0, 1, 3);
      wait_until(t+4);
      fault = 1'b0;
      wait_until(t+6);
      bus.fault_clear = 1'b1;
      wait_until(t+7);
      bus.fault_clear = 1'b0;
      wait_until(t+8);
      bus.arm = 1'b0;
      bus.fault_clear = 1'b1;
      push(t+9, "flt_exit", ST_IDLE, 0, 0, 0, 3);
      wait_until(t+9);
      bus.fault_clear = 1'b0;
      wait_until(t+11);

      // maximum stagger
      t = cyc;
      bus.dac_delay = 16'hFFFF;
      bus.arm = 1'b1;
      push(t+1, "max_ram_up", ST_RAM_UP, 1, 0, 0, 3);
      push(t+65537, "max_run", ST_RUN, 1, 1, 0, 4);
      wait_until(t+65539);
      t = cyc;
      bus.arm = 1'b0;
      push(t+1, "max_dac_down", ST_DAC_DOWN, 1, 0, 0, 4);
      push(t+2, "max_idle", ST_IDLE, 0, 0, 0, 4);
      wait_until(t+4);

      // run_count saturation from a preload
      t = cyc;
      force dut.run_count_q = 16'hFFFE;
      push(t+1, "sat_preload", ST_IDLE, 0, 0, 0, 16'hFFFE);
      wait_until(t+1);
      release dut.run_count_q;
      wait_until(t+2);
      t = cyc;
      bus.dac_delay = 16'd0;
      bus.arm = 1'b1;
      push(t+1, "sat_ram_up1", ST_RAM_UP, 1, 0, 0, 16'hFFFE);
      push(t+2, "sat_run1", ST_RUN, 1, 1, 0, 16'hFFFF);
      wait_until(t+3);
      bus.arm = 1'b0;
      push(t+4, "sat_dac_down", ST_DAC_DOWN, 1, 0, 0, 16'hFFFF);
      push(t+5, "sat_idle", ST_IDLE, 0, 0, 0, 16'hFFFF);
      wait_until(t+6);
      bus.arm = 1'b1;
      push(t+7, "sat_ram_up2", ST_RAM_UP, 1, 0, 0, 16'hFFFF);
      push(t+8, "sat_run2", ST_RUN, 1, 1, 0, 16'hFFFF);
      wait_until(t+10);

      // async reset in RUN, no clock edge needed
      @(posedge clk);
      #2;
      t = cyc;
      rst_n = 1'b0;
      bus.arm = 1'b0;
      #1;
      chk("arst_wr", int'(wr), 0);
      chk("arst_dac", int'(dac), 0);
      chk("arst_state", int'(bus.seq_state), 0);
      chk("arst_rc", int'(bus.run_count), 0);
      push(t+1, "arst_restore", ST_IDLE, 0, 0, 0, 0);
      wait_until(t+2);
      rst_n = 1'b1;
      wait_until(t+3);
      t = cyc;
      bus.dac_delay = 16'd1;
      bus.arm = 1'b1;
      push(t+1, "post_ram_up", ST_RAM_UP, 1, 0, 0, 0);
      push(t+3, "post_run", ST_RUN, 1, 1, 0, 1);
      wait_until(t+6);

      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending: got %0d unseen events, want 0",
                  exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed",
               tests, fails);
      $finish;
   end

endmodule
